ring_sequence_checker: RTL and testbench
========================================

RING_SEQUENCE_CHECKER -- requirements
Module: ring_sequence_checker

Interface
REQ-001 The block SHALL have parameter LOCK_CNT, default 3: the number of consecutive in-order one-hot samples needed to declare lock (legal range 2..15).
REQ-002 The block SHALL have parameter DIR, default 0: the expected rotation. 0 = left (0001->0010->0100->1000->0001); 1 = right (1000->0100->0010->0001->1000).
REQ-003 The block SHALL have one clock and an asynchronous, active-high reset. Ports are named clk and rst, and these two are listed first.
REQ-004 clk  input  1  rising-edge clock for all state.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 q_in  input  4  monitored 4-bit ring-counter pattern.
REQ-007 sample_en  input  1  sample strobe; q_in is evaluated only on cycles where sample_en=1.
REQ-008 err_clr  input  1  synchronous clear of err_count.
REQ-009 idx  output  2  binary position of the set bit in the last one-hot sample.
REQ-010 onehot_ok  output  1  the last evaluated sample was exactly one-hot.
REQ-011 locked  output  1  the FSM is in the LOCKED state.
REQ-012 seq_err  output  1  one-cycle pulse on loss of sequence while locked.
REQ-013 err_count  output  8  saturating count of seq_err events.

Function
REQ-014 All outputs SHALL be registered, with 1-cycle latency from the sampling edge to the output update.
REQ-015 A sample SHALL be one-hot only if exactly one bit of q_in is set. 0000 and any multi-bit pattern are illegal.
REQ-016 On a one-hot sample, idx SHALL load the set bit's position (0001->0, 0010->1, 0100->2, 1000->3). On an illegal sample, idx SHALL hold its previous value.
REQ-017 onehot_ok SHALL update only on cycles where sample_en=1.
REQ-018 The expected next value SHALL be the previous accepted one-hot sample rotated by one position in direction DIR. Wrap-around is legal: 1000->0001 for DIR=0, 0001->1000 for DIR=1.
REQ-019 The FSM SHALL have three states: SEARCH, TRACK and LOCKED. It SHALL also hold a 4-bit run counter and a 4-bit register storing the last accepted sample.
REQ-020 In SEARCH, a one-hot sample SHALL store the sample, set run=1 and move the FSM to TRACK. An illegal sample SHALL leave the FSM in SEARCH.
REQ-021 In TRACK, a sample equal to the expected value SHALL store it and increment run. When run reaches LOCK_CNT, the FSM SHALL move to LOCKED.
REQ-022 In TRACK, a one-hot sample that is out of order SHALL store it, set run=1 and keep the FSM in TRACK. An illegal sample SHALL return the FSM to SEARCH with run=0.
REQ-023 In LOCKED, an expected sample SHALL keep the FSM in LOCKED and store the sample.
REQ-024 In LOCKED, an unexpected or illegal sample SHALL:
- assert seq_err for exactly one cycle;
- increment err_count;
- if the sample is one-hot, move the FSM to TRACK with run=1 and store the sample;
- otherwise, move the FSM to SEARCH.
REQ-025 seq_err SHALL never assert outside a LOCKED->not-LOCKED transition.
REQ-026 When sample_en=0, all state SHALL hold and seq_err SHALL be 0.
REQ-027 A repeated identical sample (a stalled ring) SHALL count as a mismatch.
REQ-028 err_count SHALL saturate at 255 and never wrap.
REQ-029 When err_clr=1 and no error occurs in that cycle, err_count SHALL become 0 on the next edge.
REQ-030 When err_clr=1 coincides with an error, err_count SHALL become 1.
REQ-031 locked SHALL be 1 exactly while the FSM state is LOCKED.

Reset
REQ-032 While rst=1, regardless of clk, the outputs and internal registers SHALL be:
- FSM state = SEARCH;
- run = 0;
- stored sample = 0000;
- idx = 0;
- onehot_ok = 0;
- locked = 0;
- seq_err = 0;
- err_count = 0.
REQ-033 Asserting rst mid-operation, including while LOCKED or during a seq_err pulse, SHALL clear everything immediately. After release, the first qualifying sample SHALL be treated as a SEARCH sample.

Verification
REQ-034 Lock: DIR=0, LOCK_CNT=3, sample_en=1, q_in = 0001, 0010, 0100 -> locked=1 one cycle after the third sample; idx=2; seq_err=0.
REQ-035 Wrap: while locked (DIR=0), q_in = 1000 then 0001 -> locked stays 1, idx=3 then 0, no seq_err.
REQ-036 Break: while locked, last sample 0010, q_in=1000 -> seq_err=1 for one cycle, err_count=1, locked=0, FSM in TRACK. Then 0001, 0010 -> relock.
REQ-037 Illegal pattern: while locked, q_in=0110 -> seq_err pulse, onehot_ok=0, idx held, FSM in SEARCH. Then q_in=0000 -> no further seq_err.
REQ-038 Counter limits: force 300 lock/break cycles -> err_count=255. Then err_clr=1 with no error -> err_count=0. Then err_clr coinciding with a break -> err_count=1.
REQ-039 Reset and gating:
- assert rst asynchronously mid-LOCKED -> all outputs 0 before the next clk edge;
- hold sample_en=0 with toggling q_in -> no state or output change.

Source files
------------

// File: rtl/ring_sequence_checker.sv
// Ring-counter sequence checker: tracks a rotating one-hot pattern,
// declares lock after LOCK_CNT in-order samples and counts sequence losses.
module ring_sequence_checker #(
    parameter int LOCK_CNT = 3,
    parameter int DIR      = 0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] q_in,
    input  logic       sample_en,
    input  logic       err_clr,
    output logic [1:0] idx,
    output logic       onehot_ok,
    output logic       locked,
    output logic       seq_err,
    output logic [7:0] err_count
);

    typedef enum logic [1:0] {
        SEARCH = 2'd0,
        TRACK  = 2'd1,
        LOCKED = 2'd2
    } state_t;

    localparam logic [3:0] LOCK_RUN = 4'(LOCK_CNT);

    state_t     state_q;
    logic [3:0] run_q;
    logic [3:0] last_q;
    logic [1:0] idx_q;
    logic       onehot_q;
    logic       seq_err_q;
    logic [7:0] err_count_q;

    logic       is_onehot;
    logic [3:0] expected;
    logic       match;
    logic       err_evt;
    logic [1:0] idx_d;
    logic [3:0] run_inc;
    logic [7:0] err_count_d;

    // Classify the incoming sample against the rotation of the last one.
    always_comb begin
        is_onehot = (q_in != 4'd0) && ((q_in & (q_in - 4'd1)) == 4'd0);
        if (DIR == 0) begin
            expected = {last_q[2:0], last_q[3]};
        end else begin
            expected = {last_q[0], last_q[3:1]};
        end
        match   = is_onehot && (q_in == expected);
        err_evt = sample_en && (state_q == LOCKED) && !match;
        run_inc = run_q + 4'd1;
        idx_d   = idx_q;
        case (q_in)
            4'b0001: idx_d = 2'd0;
            4'b0010: idx_d = 2'd1;
            4'b0100: idx_d = 2'd2;
            4'b1000: idx_d = 2'd3;
            default: idx_d = idx_q;
        endcase
    end

    // Error counter: an error in the same cycle as a clear leaves one count.
    always_comb begin
        err_count_d = err_count_q;
        if (err_evt) begin
            if (err_clr) begin
                err_count_d = 8'd1;
            end else if (err_count_q != 8'hFF) begin
                err_count_d = err_count_q + 8'd1;
            end
        end else if (err_clr) begin
            err_count_d = 8'd0;
        end
    end

    // Lock FSM with run counter, stored sample and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= SEARCH;
            run_q       <= 4'd0;
            last_q      <= 4'd0;
            idx_q       <= 2'd0;
            onehot_q    <= 1'b0;
            seq_err_q   <= 1'b0;
            err_count_q <= 8'd0;
        end else begin
            seq_err_q   <= err_evt;
            err_count_q <= err_count_d;
            if (sample_en) begin
                onehot_q <= is_onehot;
                idx_q    <= idx_d;
                case (state_q)
                    SEARCH: begin
                        if (is_onehot) begin
                            last_q  <= q_in;
                            run_q   <= 4'd1;
                            state_q <= TRACK;
                        end
                    end
                    TRACK: begin
                        if (match) begin
                            last_q <= q_in;
                            run_q  <= run_inc;
                            if (run_inc >= LOCK_RUN) begin
                                state_q <= LOCKED;
                            end
                        end else if (is_onehot) begin
                            last_q <= q_in;
                            run_q  <= 4'd1;
                        end else begin
                            run_q   <= 4'd0;
                            state_q <= SEARCH;
                        end
                    end
                    LOCKED: begin
                        if (match) begin
                            last_q <= q_in;
                        end else if (is_onehot) begin
                            last_q  <= q_in;
                            run_q   <= 4'd1;
                            state_q <= TRACK;
                        end else begin
                            run_q   <= 4'd0;
                            state_q <= SEARCH;
                        end
                    end
                    default: begin
                        run_q   <= 4'd0;
                        state_q <= SEARCH;
                    end
                endcase
            end
        end
    end

    assign idx       = idx_q;
    assign onehot_ok = onehot_q;
    assign locked    = (state_q == LOCKED);
    assign seq_err   = seq_err_q;
    assign err_count = err_count_q;

endmodule

// File: tb/tb_ring_sequence_checker.sv
// Directed bench for ring_sequence_checker (DIR=0, LOCK_CNT=3).
// Hand-computed expectations checked one cycle after each sampling edge.
module tb_ring_sequence_checker;

    logic       clk;
    logic       rst;
    logic [3:0] q_in;
    logic       sample_en;
    logic       err_clr;
    logic [1:0] idx;
    logic       onehot_ok;
    logic       locked;
    logic       seq_err;
    logic [7:0] err_count;

    int n_vec;
    int n_bad;

    ring_sequence_checker #(.LOCK_CNT(3), .DIR(0)) dut (
        .clk       (clk),
        .rst       (rst),
        .q_in      (q_in),
        .sample_en (sample_en),
        .err_clr   (err_clr),
        .idx       (idx),
        .onehot_ok (onehot_ok),
        .locked    (locked),
        .seq_err   (seq_err),
        .err_count (err_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Apply one sample, then wait until 1 time unit after the clock edge.
    task automatic step(input logic [3:0] q, input logic en,
                        input logic clr);
        q_in      = q;
        sample_en = en;
        err_clr   = clr;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_all(input string tag, input logic [1:0] e_idx,
                           input logic e_ok, input logic e_lk,
                           input logic e_se, input logic [7:0] e_ec);
        chk({tag, ".idx"}, 32'(idx), 32'(e_idx));
        chk({tag, ".ok"}, 32'(onehot_ok), 32'(e_ok));
        chk({tag, ".lock"}, 32'(locked), 32'(e_lk));
        chk({tag, ".serr"}, 32'(seq_err), 32'(e_se));
        chk({tag, ".ecnt"}, 32'(err_count), 32'(e_ec));
    endtask

    initial begin
        n_vec     = 0;
        n_bad     = 0;
        rst       = 1'b0;
        q_in      = 4'd0;
        sample_en = 1'b0;
        err_clr   = 1'b0;
        #1 rst = 1'b1;
        @(posedge clk);
        #1;
        chk_all("reset", 2'd0, 1'b0, 1'b0, 1'b0, 8'd0);
        rst = 1'b0;

        // Lock sequence
        step(4'b0001, 1'b1, 1'b0);
        chk_all("lock1", 2'd0, 1'b1, 1'b0, 1'b0, 8'd0);
        step(4'b0010, 1'b1, 1'b0);
        chk_all("lock2", 2'd1, 1'b1, 1'b0, 1'b0, 8'd0);
        step(4'b0100, 1'b1, 1'b0);
        chk_all("lock3", 2'd2, 1'b1, 1'b1, 1'b0, 8'd0);

        // Wrap-around while locked
        step(4'b1000, 1'b1, 1'b0);
        chk_all("wrap1", 2'd3, 1'b1, 1'b1, 1'b0, 8'd0);
        step(4'b0001, 1'b1, 1'b0);
        chk_all("wrap2", 2'd0, 1'b1, 1'b1, 1'b0, 8'd0);

        // Break, then relock from TRACK with run=1
        step(4'b0010, 1'b1, 1'b0);
        chk_all("pre_brk", 2'd1, 1'b1, 1'b1, 1'b0, 8'd0);
        step(4'b1000, 1'b1, 1'b0);
        chk_all("brk", 2'd3, 1'b1, 1'b0, 1'b1, 8'd1);
        step(4'b0001, 1'b1, 1'b0);
        chk_all("brk_r1", 2'd0, 1'b1, 1'b0, 1'b0, 8'd1);
        step(4'b0010, 1'b1, 1'b0);
        chk_all("brk_r2", 2'd1, 1'b1, 1'b1, 1'b0, 8'd1);

        // Illegal pattern while locked, then zero pattern
        step(4'b0110, 1'b1, 1'b0);
        chk_all("ill", 2'd1, 1'b0, 1'b0, 1'b1, 8'd2);
        step(4'b0000, 1'b1, 1'b0);
        chk_all("zero", 2'd1, 1'b0, 1'b0, 1'b0, 8'd2);

        // Relock from SEARCH needs three samples
        step(4'b0001, 1'b1, 1'b0);
        step(4'b0010, 1'b1, 1'b0);
        chk("s_relock2.lock", 32'(locked), 32'd0);
        step(4'b0100, 1'b1, 1'b0);
        chk("s_relock3.lock", 32'(locked), 32'd1);

        // Stalled ring counts as a mismatch
        step(4'b0100, 1'b1, 1'b0);
        chk_all("stall", 2'd2, 1'b1, 1'b0, 1'b1, 8'd3);
        step(4'b1000, 1'b1, 1'b0);
        step(4'b0001, 1'b1, 1'b0);
        chk_all("stall_rl", 2'd0, 1'b1, 1'b1, 1'b0, 8'd3);

        // Sampling disabled: toggling q_in changes nothing
        step(4'b0110, 1'b0, 1'b0);
        chk_all("gate1", 2'd0, 1'b1, 1'b1, 1'b0, 8'd3);
        step(4'b1000, 1'b0, 1'b0);
        chk_all("gate2", 2'd0, 1'b1, 1'b1, 1'b0, 8'd3);
        step(4'b0000, 1'b0, 1'b0);
        chk_all("gate3", 2'd0, 1'b1, 1'b1, 1'b0, 8'd3);
        step(4'b0010, 1'b1, 1'b0);
        chk_all("gate_end", 2'd1, 1'b1, 1'b1, 1'b0, 8'd3);

        // Saturation: 300 stall/relock cycles (last accepted = 0010)
        for (int i = 0; i < 300; i++) begin
            step(4'b0010, 1'b1, 1'b0);
            step(4'b0100, 1'b1, 1'b0);
            step(4'b1000, 1'b1, 1'b0);
            q_in = 4'b0010;
            step(4'b0001, 1'b1, 1'b0);
            step(4'b0010, 1'b1, 1'b0);
        end
        chk_all("sat", 2'd1, 1'b1, 1'b1, 1'b0, 8'd255);

        // Clear without error
        step(4'b0010, 1'b0, 1'b1);
        chk_all("clr", 2'd1, 1'b1, 1'b1, 1'b0, 8'd0);
        step(4'b0100, 1'b1, 1'b0);
        step(4'b1000, 1'b1, 1'b0);
        step(4'b0001, 1'b1, 1'b0);
        chk_all("clr_hold", 2'd0, 1'b1, 1'b1, 1'b0, 8'd0);
        step(4'b0001, 1'b1, 1'b0);
        chk_all("err1", 2'd0, 1'b1, 1'b0, 1'b1, 8'd1);
        step(4'b0010, 1'b1, 1'b0);
        step(4'b0100, 1'b1, 1'b0);
        chk_all("relk", 2'd2, 1'b1, 1'b1, 1'b0, 8'd1);
        step(4'b1000, 1'b1, 1'b0);
        step(4'b0001, 1'b1, 1'b0);
        chk_all("relk2", 2'd0, 1'b1, 1'b1, 1'b0, 8'd1);
        step(4'b0010, 1'b1, 1'b0);
        step(4'b0100, 1'b1, 1'b0);
        step(4'b1000, 1'b1, 1'b0);
        chk_all("pre_clr_err", 2'd3, 1'b1, 1'b1, 1'b0, 8'd1);
        step(4'b0100, 1'b1, 1'b0);
        step(4'b0010, 1'b0, 1'b0);
        chk_all("clr_err_pre", 2'd2, 1'b1, 1'b0, 1'b0, 8'd2);
        step(4'b1000, 1'b1, 1'b0);
        step(4'b0001, 1'b1, 1'b0);
        chk("clr_err_lk", 32'(locked), 32'd1);
        step(4'b0001, 1'b1, 1'b1);
        chk_all("clr_err", 2'd0, 1'b1, 1'b0, 1'b1, 8'd1);

        // Async reset mid-LOCKED
        step(4'b0010, 1'b1, 1'b0);
        step(4'b0100, 1'b1, 1'b0);
        chk("rst_pre.lock", 32'(locked), 32'd1);
        #2 rst = 1'b1;
        #1;
        chk_all("async_rst", 2'd0, 1'b0, 1'b0, 1'b0, 8'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        step(4'b1000, 1'b1, 1'b0);
        chk_all("post1", 2'd3, 1'b1, 1'b0, 1'b0, 8'd0);
        step(4'b0001, 1'b1, 1'b0);
        chk("post2.lock", 32'(locked), 32'd0);
        step(4'b0010, 1'b1, 1'b0);
        chk_all("post3", 2'd1, 1'b1, 1'b1, 1'b0, 8'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
